gain_sweep_ctrl: RTL and testbench

Sequencer for the op-amp DC/AC gain characterisation bench. It steps the programmable bias current source through a configured sweep, waits a programmable settling time after each step for the RC load to settle, and runs 2^AVG_LOG2 ADC conversions per step through a request/acknowledge handshake. It then returns one averaged result per sweep point on a valid/ready stream, between the register interface and the bias-DAC/ADC front end.

---
 rtl/gain_sweep_pkg.sv | 18 +
 rtl/gain_sweep_ctrl_if.sv | 29 ++
 rtl/gain_sweep_ctrl_settle_timer.sv | 27 ++
 rtl/gain_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gain_sweep_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gain_sweep_pkg.sv
// Shared types and default widths for the gain-sweep sequencer.
package gain_sweep_pkg;

   localparam int DAC_W    = 8;
   localparam int ADC_W    = 12;
   localparam int SETTLE_W = 16;
   localparam int AVG_LOG2 = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      CONV,
      OUT,
      FIN
   } state_t;

endpackage

// File: rtl/gain_sweep_ctrl_if.sv
// Front-end bundle: bias DAC drive, ADC request/ack and the result stream.
interface gain_sweep_ctrl_if #(
   parameter int DAC_W = gain_sweep_pkg::DAC_W,
   parameter int ADC_W = gain_sweep_pkg::ADC_W
);

   logic [DAC_W-1:0] dac_code;
   logic             dac_load;
   logic             adc_req;
   logic             adc_ack;
   logic [ADC_W-1:0] adc_data;
   logic             res_valid;
   logic             res_ready;
   logic [DAC_W-1:0] res_code;
   logic [ADC_W-1:0] res_data;

   // Sequencer side
   modport master (
      output dac_code, dac_load, adc_req, res_valid, res_code, res_data,
      input  adc_ack, adc_data, res_ready
   );

   // Analog front end / result consumer side
   modport slave (
      input  dac_code, dac_load, adc_req, res_valid, res_code, res_data,
      output adc_ack, adc_data, res_ready
   );

endinterface

// File: rtl/gain_sweep_ctrl_settle_timer.sv
// Loadable down-counter that stops at zero; flags when the RC load has settled.
module settle_timer #(
   parameter int SETTLE_W = gain_sweep_pkg::SETTLE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load,
   input  logic [SETTLE_W-1:0] i_load_val,
   output logic                o_zero
);

   logic [SETTLE_W-1:0] r_cnt;

   // Load on request, otherwise count down and park at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - SETTLE_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gain_sweep_ctrl.sv
// Gain-sweep sequencer: steps the bias DAC, waits for settling, averages
// 2^AVG_LOG2 ADC samples per point and streams one result per point.
module gain_sweep_ctrl #(
   parameter int DAC_W    = gain_sweep_pkg::DAC_W,
   parameter int ADC_W    = gain_sweep_pkg::ADC_W,
   parameter int SETTLE_W = gain_sweep_pkg::SETTLE_W,
   parameter int AVG_LOG2 = gain_sweep_pkg::AVG_LOG2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [DAC_W-1:0]    cfg_first,
   input  logic [DAC_W-1:0]    cfg_step,
   input  logic [DAC_W-1:0]    cfg_points,
   input  logic [SETTLE_W-1:0] cfg_settle,
   output logic                busy,
   output logic                done,
   gain_sweep_ctrl_if.master   fe
);

   import gain_sweep_pkg::*;

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << AVG_LOG2) - 1);

   state_t              r_state;
   state_t              w_nxt;

   // captured configuration and sweep progress
   logic [DAC_W-1:0]    r_code;
   logic [DAC_W-1:0]    r_cfg_step;
   logic [DAC_W-1:0]    r_pts_left;
   logic [SETTLE_W-1:0] r_cfg_settle;
   logic [ACC_W-1:0]    r_acc;
   logic [CNT_W-1:0]    r_smp_cnt;

   // registered outputs
   logic [DAC_W-1:0]    r_dac_code;
   logic                r_dac_load;
   logic                r_adc_req;
   logic                r_res_valid;
   logic [DAC_W-1:0]    r_res_code;
   logic [ADC_W-1:0]    r_res_data;
   logic                r_busy;
   logic                r_done;

   logic                w_settle_load;
   logic                w_settle_zero;
   logic                w_accept;
   logic                w_last_ack;
   logic                w_hold_out;

   // Average is a plain truncating right shift of the sample sum
   function automatic logic [ADC_W-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
      return acc[ACC_W-1:AVG_LOG2];
   endfunction

   assign w_settle_load = (r_state == LOAD);
   assign w_accept      = (r_state == OUT) && r_res_valid && fe.res_ready;
   assign w_last_ack    = (r_state == CONV) && fe.adc_ack && (r_smp_cnt == LAST_SMP);
   assign w_hold_out    = (r_state == OUT) && (w_nxt == OUT);

   settle_timer #(
      .SETTLE_W (SETTLE_W)
   ) u_settle (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_settle_load),
      .i_load_val (r_cfg_settle),
      .o_zero     (w_settle_zero)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state logic; abort overrides everything outside IDLE
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_nxt = (cfg_points == '0) ? FIN : LOAD;
         LOAD:    w_nxt = SETTLE;
         SETTLE:  if (w_settle_zero) w_nxt = CONV;
         CONV:    if (w_last_ack) w_nxt = OUT;
         OUT:     if (w_accept) w_nxt = (r_pts_left > DAC_W'(1)) ? LOAD : FIN;
         FIN:     w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
      if (abort && (r_state != IDLE)) begin
         w_nxt = IDLE;
      end
   end

   // Config capture, point stepping and sample accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code       <= '0;
         r_cfg_step   <= '0;
         r_pts_left   <= '0;
         r_cfg_settle <= '0;
         r_acc        <= '0;
         r_smp_cnt    <= '0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_code       <= cfg_first;
            r_cfg_step   <= cfg_step;
            r_pts_left   <= cfg_points;
            r_cfg_settle <= cfg_settle;
         end
         if (r_state == LOAD) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
         end else if ((r_state == CONV) && fe.adc_ack) begin
            r_acc     <= r_acc + ACC_W'(fe.adc_data);
            r_smp_cnt <= r_smp_cnt + CNT_W'(1);
         end
         if (w_accept && !abort) begin
            r_code     <= r_code + r_cfg_step;
            r_pts_left <= r_pts_left - DAC_W'(1);
         end
      end
   end

   // Output registers; an abort clears the live strobes on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dac_code  <= '0;
         r_dac_load  <= 1'b0;
         r_adc_req   <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_code  <= '0;
         r_res_data  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_dac_load  <= (r_state == LOAD) && !abort;
         r_adc_req   <= (w_nxt == CONV);
         r_res_valid <= w_hold_out;
         r_busy      <= (r_state != IDLE) && !abort;
         r_done      <= (r_state == FIN) && !abort;
         if ((r_state == LOAD) && !abort) begin
            r_dac_code <= r_code;
         end
         if (w_hold_out) begin
            r_res_code <= r_code;
            r_res_data <= avg_trunc(r_acc);
         end
      end
   end

   assign fe.dac_code  = r_dac_code;
   assign fe.dac_load  = r_dac_load;
   assign fe.adc_req   = r_adc_req;
   assign fe.res_valid = r_res_valid;
   assign fe.res_code  = r_res_code;
   assign fe.res_data  = r_res_data;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_gain_sweep_ctrl.sv
// Directed bench for gain_sweep_ctrl with an ADC responder and a result scoreboard.
module tb_gain_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  cfg_first = '0;
   logic [7:0]  cfg_step = '0;
   logic [7:0]  cfg_points = '0;
   logic [15:0] cfg_settle = '0;
   logic        busy;
   logic        done;

   logic        res_ready_tb = 1'b0;
   logic        resp_ack = 1'b0;
   logic [11:0] resp_data = '0;
   logic        stray_ack = 1'b0;
   logic [11:0] stray_data = '0;
   int          data_tbl [4] = '{0, 0, 0, 0};
   int          r_wait = 0;
   int          r_idx = 0;

   typedef struct {
      logic [7:0]  code;
      logic [11:0] data;
   } exp_t;
   exp_t exp_q [$];

   int n_chk = 0;
   int n_pass = 0;

   int w_loads, w_dones, w_valids, w_first_req, w_first_done;
   int load_q [$];
   int rise_q [$];

   gain_sweep_ctrl_if #(.DAC_W(8), .ADC_W(12)) fe ();

   assign fe.adc_ack   = resp_ack | stray_ack;
   assign fe.adc_data  = stray_ack ? stray_data : resp_data;
   assign fe.res_ready = res_ready_tb;

   gain_sweep_ctrl #(
      .DAC_W    (8),
      .ADC_W    (12),
      .SETTLE_W (16),
      .AVG_LOG2 (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_first  (cfg_first),
      .cfg_step   (cfg_step),
      .cfg_points (cfg_points),
      .cfg_settle (cfg_settle),
      .busy       (busy),
      .done       (done),
      .fe         (fe)
   );

   always #5 clk = ~clk;

   // ADC model: answers a standing request after 3 cycles, cycling through data_tbl
   always @(negedge clk) begin
      if (!busy) r_idx = 0;
      if (resp_ack) begin
         resp_ack = 1'b0;
         r_wait   = 0;
      end else if (fe.adc_req) begin
         r_wait++;
         if (r_wait == 3) begin
            resp_ack  = 1'b1;
            resp_data = 12'(data_tbl[r_idx]);
            r_idx     = (r_idx + 1) % 4;
            r_wait    = 0;
         end
      end else begin
         r_wait = 0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_dac_code"},  32'(fe.dac_code),  0);
      chk({p, "_dac_load"},  32'(fe.dac_load),  0);
      chk({p, "_adc_req"},   32'(fe.adc_req),   0);
      chk({p, "_res_valid"}, 32'(fe.res_valid), 0);
      chk({p, "_res_code"},  32'(fe.res_code),  0);
      chk({p, "_res_data"},  32'(fe.res_data),  0);
      chk({p, "_busy"},      32'(busy),         0);
      chk({p, "_done"},      32'(done),         0);
   endtask

   task automatic push_exp(input logic [7:0] code, input logic [11:0] data);
      exp_t e;
      e.code = code;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("extra_result", 32'(exp_q.size()), 1);
      end else begin
         e = exp_q.pop_front();
         chk("res_code", 32'(fe.res_code), 32'(e.code));
         chk("res_data", 32'(fe.res_data), 32'(e.data));
      end
   endtask

   // Start pulse sampled on the next edge; cfg is scrambled afterwards
   task automatic do_start(input logic [7:0] first, input logic [7:0] step,
                           input logic [7:0] pts, input logic [15:0] settle);
      @(posedge clk); #1;
      cfg_first  = first;
      cfg_step   = step;
      cfg_points = pts;
      cfg_settle = settle;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      cfg_first  = 8'($urandom);
      cfg_step   = 8'($urandom);
      cfg_points = 8'($urandom);
      cfg_settle = 16'($urandom_range(50, 90));
   endtask

   // Per-cycle observer until busy falls (cycle 0 = first negedge after call)
   task automatic watch(input int max_cyc);
      bit fin = 1'b0;
      bit prev_req = 1'b0;
      w_loads = 0; w_dones = 0; w_valids = 0;
      w_first_req = -1; w_first_done = -1;
      load_q.delete();
      rise_q.delete();
      for (int c = 0; c < max_cyc && !fin; c++) begin
         @(negedge clk);
         if (fe.dac_load) begin
            w_loads++;
            load_q.push_back(c);
         end
         if (fe.adc_req && !prev_req) begin
            rise_q.push_back(c);
            if (w_first_req < 0) w_first_req = c;
         end
         prev_req = fe.adc_req;
         if (done) begin
            w_dones++;
            if (w_first_done < 0) w_first_done = c;
         end
         if (fe.res_valid) w_valids++;
         if (fe.res_valid && fe.res_ready) pop_check();
         if (c >= 1 && !busy) fin = 1'b1;
      end
      chk("watch_completed", 32'(fin), 1);
   endtask

   initial begin
      int k;
      int bad;
      int loads;
      int acks;

      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // ---- basic sweep
      data_tbl = '{100, 101, 102, 103};
      res_ready_tb = 1'b1;
      push_exp(8'd10, 12'd101);
      push_exp(8'd15, 12'd101);
      push_exp(8'd20, 12'd101);
      do_start(8'd10, 8'd5, 8'd3, 16'd4);
      watch(400);
      chk("t1_loads", w_loads, 3);
      chk("t1_dones", w_dones, 1);
      chk("t1_first_load", load_q[0], 1);
      chk("t1_first_req", w_first_req, 6);
      chk("t1_valid_cycles", w_valids, 3);
      chk("t1_sb_empty", exp_q.size(), 0);

      // ---- code wrap and zero settle, truncating average
      data_tbl = '{7, 8, 9, 11};
      push_exp(8'd250, 12'd8);
      push_exp(8'd254, 12'd8);
      push_exp(8'd2, 12'd8);
      do_start(8'd250, 8'd4, 8'd3, 16'd0);
      watch(400);
      chk("t2_loads", w_loads, 3);
      chk("t2_dones", w_dones, 1);
      chk("t2_first_req", w_first_req, 2);
      for (int i = 0; i < 3; i++) chk("t2_settle_gap", rise_q[i] - load_q[i], 1);
      chk("t2_sb_empty", exp_q.size(), 0);

      // ---- backpressure on point 1
      data_tbl = '{200, 200, 200, 204};
      res_ready_tb = 1'b0;
      push_exp(8'd40, 12'd201);
      push_exp(8'd43, 12'd201);
      do_start(8'd40, 8'd3, 8'd2, 16'd1);
      k = 0;
      while (!fe.res_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t3_valid_seen", 32'(fe.res_valid), 1);
      bad = 0;
      loads = 0;
      repeat (20) begin
         @(negedge clk);
         if (!(fe.res_valid === 1'b1 && fe.res_code === 8'd40 && fe.res_data === 12'd201)) bad++;
         if (fe.dac_load) loads++;
      end
      chk("t3_hold_stable", bad, 0);
      chk("t3_hold_no_load", loads, 0);
      @(posedge clk); #1;
      res_ready_tb = 1'b1;
      watch(300);
      chk("t3_release_load_cycle", load_q[0], 2);
      chk("t3_loads", w_loads, 1);
      chk("t3_dones", w_dones, 1);
      chk("t3_sb_empty", exp_q.size(), 0);

      // ---- zero points
      do_start(8'd99, 8'd1, 8'd0, 16'd3);
      watch(50);
      chk("t4_done_cycle", w_first_done, 1);
      chk("t4_dones", w_dones, 1);
      chk("t4_loads", w_loads, 0);
      chk("t4_no_req", w_first_req, -1);
      chk("t4_no_valid", w_valids, 0);
      chk("t4_dac_code_kept", 32'(fe.dac_code), 43);

      // ---- abort during CONV after two acks, then clean restart
      data_tbl = '{1000, 2000, 3000, 4000};
      do_start(8'd60, 8'd1, 8'd2, 16'd2);
      acks = 0;
      k = 0;
      while (acks < 2 && k < 300) begin
         @(negedge clk);
         k++;
         if (fe.adc_ack) acks++;
      end
      chk("t5_two_acks", acks, 2);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t5_req_dropped", 32'(fe.adc_req), 0);
      chk("t5_busy_dropped", 32'(busy), 0);
      chk("t5_no_valid", 32'(fe.res_valid), 0);
      chk("t5_dac_code_kept", 32'(fe.dac_code), 60);
      stray_data = 12'hFFF;
      stray_ack  = 1'b1;
      @(posedge clk); #1;
      stray_ack  = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (fe.adc_req || busy || done || fe.res_valid || fe.dac_load) bad++;
      end
      chk("t5_quiet_after_abort", bad, 0);
      push_exp(8'd60, 12'd2500);
      push_exp(8'd61, 12'd2500);
      do_start(8'd60, 8'd1, 8'd2, 16'd2);
      watch(400);
      chk("t5_restart_dones", w_dones, 1);
      chk("t5_restart_loads", w_loads, 2);
      chk("t5_sb_empty", exp_q.size(), 0);

      // ---- asynchronous reset while a result is pending
      data_tbl = '{16, 16, 16, 16};
      res_ready_tb = 1'b0;
      do_start(8'd77, 8'd1, 8'd2, 16'd0);
      k = 0;
      while (!fe.res_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("t6_valid_seen", 32'(fe.res_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("t6_async");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_idle_after_reset", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
